// File: rtl/pc_sequencer.sv
// Control sequencer for program_counter: one-hot PC select lines, link stack, halt/fault hold.
// Outputs are combinational from state and decoder strobes; stack and state update on clk.
module pc_sequencer #(
  parameter int STACK_DEPTH = 4,
  parameter int PC_W        = 10
) (
  input  logic            clk,
  input  logic            start,
  input  logic            dec_halt,
  input  logic            dec_call,
  input  logic            dec_ret,
  input  logic            dec_bz,
  input  logic            dec_bnz,
  input  logic            dec_jz,
  input  logic            dec_jnz,
  input  logic            dec_lj,
  input  logic [1:0]      dec_lj_sel,
  input  logic            zero,
  input  logic [PC_W-1:0] rp,
  input  logic [PC_W-1:0] npc,
  output logic            branch,
  output logic            bizr,
  output logic            bnzr,
  output logic            jizr,
  output logic            jnzr,
  output logic            jump2sub,
  output logic            retFsub,
  output logic            lj0,
  output logic            lj1,
  output logic            lj2,
  output logic            lj3,
  output logic [PC_W-1:0] rl,
  output logic            done,
  output logic            fault,
  output logic [3:0]      depth
);

  localparam int         IW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0] DMAX = 4'(STACK_DEPTH);

  typedef enum logic [1:0] {S_RST, S_RUN, S_HALT, S_FAULT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_stack [STACK_DEPTH];
  logic [3:0]      r_depth;
  logic            w_push;
  logic            w_pop;
  logic [IW-1:0]   w_wr_idx;
  logic [IW-1:0]   w_rd_idx;

  assign w_wr_idx = IW'(r_depth);
  assign w_rd_idx = IW'(r_depth - 4'd1);
  assign depth    = start ? 4'd0 : r_depth;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    branch      = 1'b0;
    bizr        = 1'b0;
    bnzr        = 1'b0;
    jizr        = 1'b0;
    jnzr        = 1'b0;
    jump2sub    = 1'b0;
    retFsub     = 1'b0;
    lj0         = 1'b0;
    lj1         = 1'b0;
    lj2         = 1'b0;
    lj3         = 1'b0;
    rl          = '0;
    done        = 1'b0;
    fault       = 1'b0;
    if (start) begin
      w_state_nxt = S_RST;
    end else begin
      unique case (r_state)
        S_RST: w_state_nxt = S_RUN;
        S_RUN: begin
          // Halt/fault detection cycles drive no select, so the PC steps to npc once.
          if (dec_halt) begin
            w_state_nxt = S_HALT;
          end else if (dec_ret) begin
            if (r_depth == 4'd0) begin
              w_state_nxt = S_FAULT;
            end else begin
              retFsub = 1'b1;
              rl      = r_stack[w_rd_idx];
              w_pop   = 1'b1;
            end
          end else if (dec_call) begin
            if (r_depth == DMAX) begin
              w_state_nxt = S_FAULT;
            end else begin
              jump2sub = 1'b1;
              w_push   = 1'b1;
            end
          end else if (dec_jz | dec_jnz | dec_bz | dec_bnz) begin
            // The first strobe in jz, jnz, bz, bnz order decides; a not-taken winner yields npc.
            if (dec_jz) begin
              jizr = zero;
            end else if (dec_jnz) begin
              jnzr = !zero;
            end else if (dec_bz) begin
              bizr = zero;
            end else begin
              bnzr = !zero;
            end
            branch = jizr | jnzr | bizr | bnzr;
          end else if (dec_lj) begin
            lj0 = (dec_lj_sel == 2'd0);
            lj1 = (dec_lj_sel == 2'd1);
            lj2 = (dec_lj_sel == 2'd2);
            lj3 = (dec_lj_sel == 2'd3);
          end
        end
        S_HALT: begin
          retFsub = 1'b1;
          rl      = rp;
          done    = 1'b1;
        end
        S_FAULT: begin
          retFsub = 1'b1;
          rl      = rp;
          fault   = 1'b1;
        end
        default: w_state_nxt = S_RST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      r_state <= S_RST;
      r_depth <= 4'd0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_stack[w_wr_idx] <= npc;
        r_depth           <= r_depth + 4'd1;
      end else if (w_pop) begin
        r_depth <= r_depth - 4'd1;
      end
    end
  end

endmodule
